task_1_out: RTL and testbench

Output stage of task 1, directly downstream of the task input stage. It consumes the word stream the input stage drains from its FIFO (data plus enable) and buffers one frame of NUM_WORDS words. It re-emits the frame on an AXI-Stream-style master interface with backpressure and TLAST. After the last word of the frame is accepted, it pulses the frame-done strobe that the input stage uses to request the next frame.

---
 rtl/task_1_pkg.sv | 26 ++
 rtl/task_1_out_fifo.sv | 74 +++++++
 rtl/task_1_out.sv | 123 ++++++++++++
 tb/tb_task_1_out.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/task_1_pkg.sv
// Shared definitions for the task-1 input and output stages.
// State encoding plus helpers deriving counter width and buffer depth from the frame size.
package task_1_pkg;

  typedef enum logic [1:0] {
    s_IDLE   = 2'd0,
    s_STREAM = 2'd1,
    s_DONE   = 2'd2
  } task_output_enum;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_WORDS  = 243;

  // Counters must reach NUM_WORDS itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned num_words);
    return $clog2(num_words + 1);
  endfunction

  function automatic int unsigned buf_depth_for(input int unsigned num_words);
    return 1 << $clog2(num_words);
  endfunction

  localparam int unsigned DEF_CNT_W     = cnt_width(DEF_NUM_WORDS);
  localparam int unsigned DEF_BUF_DEPTH = buf_depth_for(DEF_NUM_WORDS);

endpackage

// File: rtl/task_1_out_fifo.sv
// Single-clock synchronous FIFO, registered read data (latency 1), synchronous active-low reset.
// Reads when empty are ignored; a write when full is accepted only if a read frees a slot the same cycle.
module task_1_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_fire, rd_fire;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_DEPTH);
    rd_fire  = rd_en && !empty;
    wr_fire  = wr_en && (!full || rd_fire);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_data_d = rd_data_q;
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/task_1_out.sv
// Task-1 output stage: buffers one frame, re-emits it cut-through on a valid/ready master with TLAST,
// then pulses o_output_last for one cycle. Pipeline is FIFO -> read stage -> output register.
module task_1_out
  import task_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter int unsigned BUF_DEPTH  = buf_depth_for(NUM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enb,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_output_last,
  output logic                  o_overflow
);

  localparam int unsigned CNT_W = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  task_output_enum       state_q, state_d;
  logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic                  stg_vld_q, stg_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  ovf_q, ovf_d;

  logic                  fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] fifo_rd_dat;
  logic                  hs, tlast, out_free, xfer, stg_free, in_room;

  task_1_out_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .wr_en  (fifo_wr),
    .wr_data(i_data),
    .rd_en  (fifo_rd),
    .rd_data(fifo_rd_dat),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= s_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_IDLE:   if (i_enb) state_d = s_STREAM;
      s_STREAM: if (hs && tlast) state_d = s_DONE;
      s_DONE:   state_d = s_IDLE;
      default:  state_d = s_IDLE;
    endcase
  end

  always_comb begin
    o_output_last = (state_q == s_DONE);
  end

  // The read stage holds FIFO data for one cycle so a stalled output register never loses a word in flight.
  always_comb begin
    hs       = out_vld_q && i_tready;
    tlast    = out_vld_q && (out_cnt_q == CNT_LAST);
    out_free = !out_vld_q || hs;
    xfer     = stg_vld_q && out_free;
    stg_free = !stg_vld_q || xfer;
    fifo_rd  = !fifo_empty && stg_free;

    stg_vld_d = fifo_rd ? 1'b1 : (xfer ? 1'b0 : stg_vld_q);
    out_vld_d = xfer ? 1'b1 : (hs ? 1'b0 : out_vld_q);
    out_dat_d = xfer ? fifo_rd_dat : out_dat_q;

    in_room = (state_q == s_DONE) || (in_cnt_q < CNT_FULL);
    fifo_wr = i_enb && in_room && (!fifo_full || fifo_rd);
    ovf_d   = ovf_q || (i_enb && !fifo_wr);

    if (state_q == s_DONE) begin
      in_cnt_d  = fifo_wr ? CNT_W'(1) : '0;
      out_cnt_d = '0;
    end else begin
      in_cnt_d  = fifo_wr ? in_cnt_q + CNT_W'(1) : in_cnt_q;
      out_cnt_d = hs ? out_cnt_q + CNT_W'(1) : out_cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      stg_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      stg_vld_q <= stg_vld_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_tdata    = out_dat_q;
  assign o_tvalid   = out_vld_q;
  assign o_tlast    = tlast;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_task_1_out.sv
// Directed bench for task_1_out: a 4-word-frame instance and an 8-word/8-deep instance share stimulus.
module tb_task_1_out;

  logic       i_clk = 1'b0;
  logic       i_rst, i_enb, i_tready;
  logic [7:0] i_data;

  logic [7:0] tdata4, tdata8;
  logic       tvalid4, tlast4, olast4, ovf4;
  logic       tvalid8, tlast8, olast8, ovf8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] q4[$];
  logic [8:0] q8[$];
  int         hs4_cyc[$];
  int         ol4_n, ol8_n, ol4_cyc;
  logic [7:0] exp_q[$];
  logic       stall4;
  logic [7:0] hold_dat;
  logic       hold_last;
  int         c0;

  task_1_out #(.DATA_WIDTH(8), .NUM_WORDS(4), .BUF_DEPTH(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_enb(i_enb),
    .o_tdata(tdata4), .o_tvalid(tvalid4), .i_tready(i_tready), .o_tlast(tlast4),
    .o_output_last(olast4), .o_overflow(ovf4)
  );

  task_1_out #(.DATA_WIDTH(8), .NUM_WORDS(8), .BUF_DEPTH(8)) u_dut8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_enb(i_enb),
    .o_tdata(tdata8), .o_tvalid(tvalid8), .i_tready(i_tready), .o_tlast(tlast8),
    .o_output_last(olast8), .o_overflow(ovf8)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes are the cycles where valid and ready are both high just before the rising edge.
  always @(negedge i_clk) begin
    if (tvalid4 === 1'b1 && i_tready === 1'b1) begin
      q4.push_back({tlast4, tdata4});
      hs4_cyc.push_back(cyc);
    end
    if (tvalid8 === 1'b1 && i_tready === 1'b1) q8.push_back({tlast8, tdata8});
    if (olast4 === 1'b1) begin
      ol4_n++;
      ol4_cyc = cyc;
    end
    if (olast8 === 1'b1) ol8_n++;
    if (i_rst !== 1'b1) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        chk("hold_vld", tvalid4, 1);
        chk("hold_dat", tdata4, hold_dat);
        chk("hold_last", tlast4, hold_last);
      end
      stall4    = tvalid4 && !i_tready;
      hold_dat  = tdata4;
      hold_last = tlast4;
    end
  end

  function automatic logic [8:0] q_at(input bit sel, input int i);
    if (sel) return (i < q8.size()) ? q8[i] : 'x;
    return (i < q4.size()) ? q4[i] : 'x;
  endfunction

  task automatic clr();
    q4.delete(); q8.delete(); hs4_cyc.delete(); exp_q.delete();
    ol4_n = 0; ol8_n = 0; ol4_cyc = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    i_enb  = 1'b1;
    i_data = d;
    exp_q.push_back(d);
    tick(1);
    i_enb = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b0; i_enb = 1'b0; i_data = '0; i_tready = 1'b1;
    tick(1);
    i_rst = 1'b1;
    tick(1);
    clr();
  endtask

  task automatic wait_ol(input bit sel, input int target, input int max);
    int n = 0;
    while (((sel ? ol8_n : ol4_n) < target) && n < max) begin
      tick(1);
      n++;
    end
    chk("ol_timeout", ((sel ? ol8_n : ol4_n) >= target), 1);
  endtask

  task automatic check_q(input bit sel, input string tag, input int nw);
    logic [8:0] e;
    chk({tag, "_count"}, sel ? q8.size() : q4.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      e = q_at(sel, i);
      chk({tag, "_dat"}, e[7:0], exp_q[i]);
      chk({tag, "_last"}, e[8], ((i + 1) % nw) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stall4 = 1'b0;
    clr();
    i_rst = 1'b0; i_enb = 1'b0; i_data = '0; i_tready = 1'b0;
    tick(2);
    chk("rst_tvalid", tvalid4, 0);
    chk("rst_tdata", tdata4, 0);
    chk("rst_tlast", tlast4, 0);
    chk("rst_olast", olast4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_tvalid8", tvalid8, 0);

    // Nominal frame at full rate: first word out three cycles after its i_enb, then one per cycle.
    do_reset();
    c0 = cyc;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_ol(0, 1, 40);
    tick(2);
    check_q(0, "nom", 4);
    chk("nom_lat", hs4_cyc.size() > 0 ? hs4_cyc[0] : -1, c0 + 3);
    chk("nom_thru", hs4_cyc.size() > 3 ? hs4_cyc[3] : -1, c0 + 6);
    chk("nom_ol_cyc", ol4_cyc, c0 + 7);
    chk("nom_ol_n", ol4_n, 1);
    chk("nom_ovf", ovf4, 0);

    // Backpressure with ready pattern 1,0,0,1.
    do_reset();
    fork
      begin
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      end
      begin
        for (int i = 0; i < 24; i++) begin
          i_tready = (i % 4 == 0) || (i % 4 == 3);
          tick(1);
        end
        i_tready = 1'b1;
      end
    join
    wait_ol(0, 1, 40);
    tick(2);
    check_q(0, "bp", 4);
    chk("bp_ol_n", ol4_n, 1);

    // Fifth word of a 4-word frame is dropped and the error sticks.
    do_reset();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    i_enb = 1'b1; i_data = 8'h05; tick(1); i_enb = 1'b0;
    wait_ol(0, 1, 40);
    tick(6);
    check_q(0, "ovf", 4);
    chk("ovf_flag", ovf4, 1);
    chk("ovf_ol_n", ol4_n, 1);
    do_reset();
    chk("ovf_clr", ovf4, 0);

    // 8-word frame fully buffered while stalled, then a ninth word.
    do_reset();
    i_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i));
    tick(3);
    chk("full_ovf0", ovf8, 0);
    chk("full_vld", tvalid8, 1);
    chk("full_dat", tdata8, 8'h80);
    i_enb = 1'b1; i_data = 8'h88; tick(1); i_enb = 1'b0;
    chk("full_ovf1", ovf8, 1);
    i_tready = 1'b1;
    wait_ol(1, 1, 40);
    tick(2);
    check_q(1, "full", 8);
    chk("full_ol_n", ol8_n, 1);

    // Reset mid-frame clears everything; the next frame is clean.
    do_reset();
    i_tready = 1'b0;
    send(8'hB0); send(8'hB1);
    tick(2);
    chk("mid_pre_vld", tvalid4, 1);
    i_rst = 1'b0;
    tick(1);
    chk("mid_tvalid", tvalid4, 0);
    chk("mid_tdata", tdata4, 0);
    chk("mid_tlast", tlast4, 0);
    chk("mid_olast", olast4, 0);
    chk("mid_ovf", ovf4, 0);
    i_rst = 1'b1;
    i_tready = 1'b1;
    clr();
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    wait_ol(0, 1, 40);
    tick(2);
    check_q(0, "mid", 4);

    // Second frame starts in the o_output_last cycle.
    do_reset();
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    begin
      int n = 0;
      while (olast4 !== 1'b1 && n < 40) begin
        tick(1);
        n++;
      end
    end
    chk("b2b_sync", olast4, 1);
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    wait_ol(0, 2, 40);
    tick(2);
    check_q(0, "b2b", 4);
    chk("b2b_ol_n", ol4_n, 2);
    chk("b2b_ovf", ovf4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
